// File: rtl/led_port_arbiter_if.sv
// Bundle between the LED-port arbiter, its requesters and the red-LED PIO s1 slave.
// master = the arbiter itself; slave = requesters plus the PIO.
interface led_port_arbiter_if #(
    parameter int NUM_REQ = 3,
    parameter int DATA_W  = 18
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        grant;
    logic                      busy;
    logic [2:0]                last_owner;
    logic                      pio_chipselect;
    logic                      pio_write_n;
    logic [1:0]                pio_address;
    logic [DATA_W-1:0]         pio_writedata;

    modport master (
        input  req, req_data,
        output grant, busy, last_owner,
        output pio_chipselect, pio_write_n, pio_address, pio_writedata
    );

    modport slave (
        output req, req_data,
        input  grant, busy, last_owner,
        input  pio_chipselect, pio_write_n, pio_address, pio_writedata
    );
endinterface

// File: rtl/led_port_arbiter.sv
// Round-robin arbiter that is the sole Avalon-MM writer of the red-LED PIO:
// one single-cycle write per grant, followed by a fixed idle gap.
module led_port_arbiter #(
    parameter int NUM_REQ    = 3,
    parameter int DATA_W     = 18,
    parameter int GAP_CYCLES = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    led_port_arbiter_if.master  bus
);

    typedef enum logic [1:0] {IDLE, WRITE, GAP} state_e;

    localparam logic [7:0] GAP_LOAD = 8'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [3:0] NREQ4    = 4'(NUM_REQ);

    state_e                           state_q, state_d;
    logic [7:0]                       cnt_q, cnt_d;
    logic [2:0]                       ptr_q, ptr_d;
    logic [2:0]                       owner_q, owner_d;
    logic [DATA_W-1:0]                wdata_q, wdata_d;
    logic [NUM_REQ-1:0]               grant_q, grant_d;
    logic                             cs_q, cs_d;
    logic                             wn_q, wn_d;
    logic                             busy_q, busy_d;

    logic [NUM_REQ-1:0][DATA_W-1:0]   data_arr;
    logic [NUM_REQ-1:0]               rot;
    logic                             found;
    logic [2:0]                       win;
    logic [3:0]                       sum;
    logic [DATA_W-1:0]                wsel;

    assign data_arr = bus.req_data;

    // Rotate req so bit 0 is the pointer's requester; the first set bit wins.
    always_comb begin
        rot   = NUM_REQ'({bus.req, bus.req} >> ptr_q);
        found = 1'b0;
        win   = ptr_q;
        sum   = 4'd0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && rot[k]) begin
                found = 1'b1;
                sum   = {1'b0, ptr_q} + 4'(k);
                if (sum >= NREQ4) sum = sum - NREQ4;
                win   = sum[2:0];
            end
        end
        wsel = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (win == 3'(j)) wsel = data_arr[j];
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (found) state_d = WRITE;
            end
            WRITE: begin
                state_d = (GAP_CYCLES > 0) ? GAP : IDLE;
                cnt_d   = GAP_LOAD;
            end
            GAP: begin
                if (cnt_q == 8'd0) state_d = IDLE;
                else               cnt_d   = cnt_q - 8'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    // Output logic: next values of the registered outputs
    always_comb begin
        cs_d    = 1'b0;
        wn_d    = 1'b1;
        grant_d = '0;
        wdata_d = wdata_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        busy_d  = (state_d != IDLE);
        if (state_q == IDLE && found) begin
            cs_d    = 1'b1;
            wn_d    = 1'b0;
            wdata_d = wsel;
            owner_d = win;
            ptr_d   = (win == 3'(NUM_REQ - 1)) ? 3'd0 : win + 3'd1;
            for (int j = 0; j < NUM_REQ; j++) begin
                grant_d[j] = (win == 3'(j));
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cs_q    <= 1'b0;
            wn_q    <= 1'b1;
            grant_q <= '0;
            wdata_q <= '0;
            owner_q <= '0;
            ptr_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            cs_q    <= cs_d;
            wn_q    <= wn_d;
            grant_q <= grant_d;
            wdata_q <= wdata_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.pio_chipselect = cs_q;
    assign bus.pio_write_n    = wn_q;
    assign bus.pio_address    = 2'd0;
    assign bus.pio_writedata  = wdata_q;
    assign bus.grant          = grant_q;
    assign bus.busy           = busy_q;
    assign bus.last_owner     = owner_q;

endmodule

// File: tb/tb_led_port_arbiter.sv
// Directed bench: one arbiter with a 4-cycle gap, one with no gap.
module tb_led_port_arbiter;

    localparam logic [17:0] D0 = 18'h00111;
    localparam logic [17:0] D1 = 18'h2A5A5;
    localparam logic [17:0] D2 = 18'h3C0F0;
    localparam logic [17:0] DB = 18'h15555;

    logic clk = 1'b0;
    logic reset_n;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    led_port_arbiter_if #(.NUM_REQ(3), .DATA_W(18)) ia ();
    led_port_arbiter_if #(.NUM_REQ(3), .DATA_W(18)) ib ();

    led_port_arbiter #(.NUM_REQ(3), .DATA_W(18), .GAP_CYCLES(4)) dut_a (
        .clk(clk), .reset_n(reset_n), .bus(ia)
    );
    led_port_arbiter #(.NUM_REQ(3), .DATA_W(18), .GAP_CYCLES(0)) dut_b (
        .clk(clk), .reset_n(reset_n), .bus(ib)
    );

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [2:0]  rr_g [3];
        logic [17:0] rr_d [3];
        rr_g[0] = 3'b010; rr_d[0] = D1;
        rr_g[1] = 3'b100; rr_d[1] = D2;
        rr_g[2] = 3'b001; rr_d[2] = D0;

        reset_n     = 1'b0;
        ia.req      = '0;
        ia.req_data = {D2, D1, D0};
        ib.req      = '0;
        ib.req_data = {D2, D1, DB};
        tick(3);
        chk("rst_cs",    32'(ia.pio_chipselect), 32'd0);
        chk("rst_wn",    32'(ia.pio_write_n),    32'd1);
        chk("rst_addr",  32'(ia.pio_address),    32'd0);
        chk("rst_wdata", 32'(ia.pio_writedata),  32'd0);
        chk("rst_grant", 32'(ia.grant),          32'd0);
        chk("rst_busy",  32'(ia.busy),           32'd0);
        chk("rst_owner", 32'(ia.last_owner),     32'd0);
        reset_n = 1'b1;
        tick();
        chk("idle_cs", 32'(ia.pio_chipselect), 32'd0);

        // Single write from requester 1
        ia.req = 3'b010;
        tick();
        chk("sw_cs",    32'(ia.pio_chipselect), 32'd1);
        chk("sw_wn",    32'(ia.pio_write_n),    32'd0);
        chk("sw_addr",  32'(ia.pio_address),    32'd0);
        chk("sw_wdata", 32'(ia.pio_writedata),  32'(D1));
        chk("sw_grant", 32'(ia.grant),          32'b010);
        chk("sw_busy",  32'(ia.busy),           32'd1);
        chk("sw_owner", 32'(ia.last_owner),     32'd1);
        ia.req = '0;
        tick();
        chk("sw_gap_cs",    32'(ia.pio_chipselect), 32'd0);
        chk("sw_gap_wn",    32'(ia.pio_write_n),    32'd1);
        chk("sw_gap_grant", 32'(ia.grant),          32'd0);
        chk("sw_hold_data", 32'(ia.pio_writedata),  32'(D1));
        tick(3);
        chk("sw_busy_n5", 32'(ia.busy), 32'd1);
        tick();
        chk("sw_idle_n6", 32'(ia.busy), 32'd0);

        // Priority rotation: grant 2, then 3'b011 goes to 0 then 1
        ia.req = 3'b100;
        tick();
        chk("pr_grant2", 32'(ia.grant),      32'b100);
        chk("pr_owner2", 32'(ia.last_owner), 32'd2);
        ia.req = 3'b011;
        tick(5);
        chk("pr_idle_grant", 32'(ia.grant), 32'd0);
        chk("pr_idle_busy",  32'(ia.busy),  32'd0);
        tick();
        chk("pr_grant0", 32'(ia.grant),         32'b001);
        chk("pr_data0",  32'(ia.pio_writedata), 32'(D0));
        tick(6);
        chk("pr_grant1", 32'(ia.grant),         32'b010);
        chk("pr_data1",  32'(ia.pio_writedata), 32'(D1));
        ia.req = '0;
        tick(5);

        // Reset in the middle of a WRITE, then round robin from requester 0
        ia.req = 3'b111;
        tick();
        chk("mr_grant_pre", 32'(ia.grant), 32'b100);
        reset_n = 1'b0;
        #1;
        chk("mr_cs",    32'(ia.pio_chipselect), 32'd0);
        chk("mr_wn",    32'(ia.pio_write_n),    32'd1);
        chk("mr_grant", 32'(ia.grant),          32'd0);
        chk("mr_busy",  32'(ia.busy),           32'd0);
        chk("mr_wdata", 32'(ia.pio_writedata),  32'd0);
        #2 reset_n = 1'b1;
        tick();
        chk("rr_grant_first", 32'(ia.grant),         32'b001);
        chk("rr_data_first",  32'(ia.pio_writedata), 32'(D0));
        for (int i = 0; i < 3; i++) begin
            tick(5);
            chk("rr_quiet", 32'(ia.grant), 32'd0);
            tick();
            chk("rr_grant", 32'(ia.grant),         32'(rr_g[i]));
            chk("rr_data",  32'(ia.pio_writedata), 32'(rr_d[i]));
        end

        // Withdrawal: request raised during GAP and dropped before IDLE
        ia.req = '0;
        tick();
        ia.req = 3'b100;
        tick(2);
        ia.req = '0;
        tick(3);
        chk("wd_grant", 32'(ia.grant),          32'd0);
        chk("wd_cs",    32'(ia.pio_chipselect), 32'd0);
        chk("wd_hold",  32'(ia.pio_writedata),  32'(D0));
        tick(3);
        chk("wd_grant_late", 32'(ia.grant), 32'd0);
        chk("wd_busy_late",  32'(ia.busy),  32'd0);

        // Zero gap: requester 0 held high gets every other cycle
        ib.req = 3'b001;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("g0_grant", 32'(ib.grant),          (i % 2 == 0) ? 32'b001 : 32'd0);
            chk("g0_cs",    32'(ib.pio_chipselect), (i % 2 == 0) ? 32'd1 : 32'd0);
        end
        chk("g0_data", 32'(ib.pio_writedata), 32'(DB));
        ib.req = '0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
